// File: rtl/register_serializer_pkg.sv
// register_serializer_pkg: state encoding and line levels shared by the serializer and a future deserializer.
package register_serializer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;
endpackage

// File: rtl/register_serializer_bit_timer.sv
// bit_timer: counts enabled clocks and ticks every BIT_CYCLES of them; clears while disabled.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  logic [CW-1:0] cnt_q;
  assign tick = enable && cnt_q == LAST;
  always_ff @(posedge clk)
    if (reset || !enable || tick) cnt_q <= '0;
    else cnt_q <= cnt_q + CW'(1);
endmodule

// File: rtl/register_serializer.sv
// register_serializer: framed parallel-to-serial transmitter (start, WIDTH data bits, stop).
module register_serializer
  import register_serializer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_data,
  output logic             busy,
  output logic             done
);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [BW-1:0] bit_q, bit_d;
  logic out_q, out_d, ready_q, busy_q, done_q, done_d, head, tick;
  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(busy_q),
    .tick  (tick)
  );
  assign sr_shift = MSB_FIRST != 0 ? sr_q << 1 : sr_q >> 1;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE:  if (in_valid && ready_q) begin state_d = START; sr_d = in_data; end
      START: if (tick) begin state_d = DATA; bit_d = '0; end
      DATA:  if (tick) begin
        if (bit_q == BIT_LAST) state_d = STOP;
        else begin sr_d = sr_shift; bit_d = bit_q + BW'(1); end
      end
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    head   = MSB_FIRST != 0 ? sr_d[WIDTH-1] : sr_d[0];
    done_d = state_q == STOP && tick;
    out_d  = state_d == DATA ? head : state_d == START ? LINE_START :
             state_d == STOP ? LINE_STOP : LINE_IDLE;
  end
  // every output is a flop computed from next state, so inputs never reach outputs combinationally
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      out_q   <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      out_q   <= out_d;
      ready_q <= state_d == IDLE;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
    end
  assign out_data = out_q;
  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: doc/register_serializer.md
Name: register_serializer

Overview:
Parallel-to-serial transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single line as a framed sequence of start bit, data bits and stop bit. It is the consuming end of a parallel holding register: the register's parallel output feeds in_data, and out_data drives a serial link toward a downstream deserializer. Each bit is held for BIT_CYCLES clocks.

Parameters:
WIDTH, 4, data bits per frame (>=1)
BIT_CYCLES, 4, clocks each serial bit is held (>=1; 1 is legal)
MSB_FIRST, 0, 0 = in_data[0] sent first; 1 = in_data[WIDTH-1] sent first

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  parallel word to send; sampled only at acceptance
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a word this cycle
out_data  output  1  serial line, registered, idle level 1
busy  output  1  frame in progress (START/DATA/STOP)
done  output  1  one-cycle pulse, frame completed

Behaviour:
- Reset (sync, active-high, sampled at rising edge): state IDLE, out_data=1, in_ready=1, busy=0, done=0, shift register=0, bit and cycle counters=0.
- Reset wins over every other event on the same edge, including in_valid&&in_ready.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: out_data=1, in_ready=1, busy=0. Acceptance = in_valid && in_ready at a rising edge (E0): in_data is captured into the shift register. After E0: state START, out_data=0, in_ready=0, busy=1.
- START: out_data=0 for BIT_CYCLES clocks, then DATA.
- DATA: WIDTH bits, each held BIT_CYCLES clocks; order per MSB_FIRST. Bit counter runs 0..WIDTH-1. After the last bit: STOP.
- STOP: out_data=1 for BIT_CYCLES clocks, then IDLE.
- Frame timing: START begins after E0; DATA bit k begins after edge E0+(k+1)*BIT_CYCLES; STOP begins after E0+(WIDTH+1)*BIT_CYCLES; IDLE, in_ready=1 and done=1 after E0+(WIDTH+2)*BIT_CYCLES. done drops on the next edge.
- During a frame, in_ready=0; in_valid and in_data are ignored. Changes on in_data never affect the word in flight.
- Back-to-back: in_valid held high is accepted on the first IDLE edge. The minimum line gap between frames is 1 clock of idle-high (the IDLE cycle), on top of the stop bit.
- Reset mid-frame: the frame is aborted, out_data=1 after the reset edge, and done is not pulsed.
- Counters: cycle counter width clog2(BIT_CYCLES) (min 1), wraps to 0 at BIT_CYCLES-1 and produces a tick. Bit counter width clog2(WIDTH) (min 1). No counter may overflow for any legal parameter value.
- out_data, in_ready, busy and done are all driven directly from flops, with no combinational path from inputs to outputs.

Decomposition:
- Shared package/include holds the state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3) and the line-level constants LINE_IDLE=1, LINE_START=0, LINE_STOP=1. A future matching deserializer reuses them.
- One sub-module: bit_timer (params BIT_CYCLES; ports clk, reset, enable, tick). It clears when enable=0 and pulses tick every BIT_CYCLES enabled clocks.
- The FSM, shift register and bit counter stay in register_serializer.

Test Plan:
1. Reset with WIDTH=4, BIT_CYCLES=2 -> out_data=1, in_ready=1, busy=0, done=0 on the first cycle after reset.
2. Send in_data=4'b1011, MSB_FIRST=0 -> line reads 0,0 | 1,1 | 1,1 | 0,0 | 1,1 | 1,1 (start, bits 1,1,0,1, stop). done pulses exactly 12 clocks after acceptance, and in_ready returns at the same time.
3. Send 4'b1011 with MSB_FIRST=1 -> data bits are 1,0,1,1; frame length is unchanged at 12 clocks.
4. Hold in_valid=1 with words 4'hA then 4'h5 -> two complete frames separated by exactly 1 idle-high cycle. Changing in_data mid-frame does not corrupt either word.
5. Assert reset in DATA bit 2 -> out_data=1 and in_ready=1 after the reset edge, no done pulse, and the next word sends cleanly.
6. BIT_CYCLES=1, WIDTH=1: send 1'b0 -> line reads 0,0,1 then idle; done pulses 3 clocks after acceptance.
